chanx_flit_tx: RTL and testbench

CHANX_FLIT_TX -- requirements
Module: chanx_flit_tx

---
 rtl/chanx_flit_tx.sv | 145 ++++++++++++++
 tb/tb_chanx_flit_tx.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/chanx_flit_tx.sv
// chanx_flit_tx: credit-based flit transmitter for the right-hand channel.
//
// Local flits enter through a valid/ready handshake into a small FIFO. A flit
// leaves on chanx_right_out whenever the FIFO holds one and a downstream credit
// is available. Credits come back as single-cycle pulses on chanx_right_in[0].
//
// Parameters
//   FIFO_DEPTH   : FIFO entries (power of two, 2..16)
//   INIT_CREDITS : downstream buffer credits after reset (1..15)
//
// Ports
//   clk             : single clock, rising edge
//   rst_n           : asynchronous active-low reset
//   in_data         : flit payload from the local source
//   in_valid        : in_data holds a flit
//   in_ready        : FIFO can accept a flit this cycle
//   chanx_right_in  : returning channel, bit 0 = credit-return pulse
//   chanx_right_out : outgoing channel, bit 32 = valid, bit 31 = parity,
//                     bits 0..30 = payload
//   credit_count    : current credit count
//   tx_state        : FSM state (IDLE=0, SEND=1, STALL=2)
//   err_credit_ovf  : sticky flag, credit returned while already at INIT_CREDITS
//
// Build option
//   CHANX_TX_PARITY_EN : when defined, bit 31 carries the even parity of the
//                        payload on valid flits; otherwise bit 31 is always 0.

module chanx_flit_tx #(
  parameter int FIFO_DEPTH   = 4,
  parameter int INIT_CREDITS = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [0:30] in_data,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [0:32] chanx_right_in,
  output logic [0:32] chanx_right_out,
  output logic [3:0]  credit_count,
  output logic [1:0]  tx_state,
  output logic        err_credit_ovf
);

  localparam int          AW         = $clog2(FIFO_DEPTH);
  localparam logic [3:0]  CREDIT_MAX = 4'(INIT_CREDITS);
  localparam logic [AW:0] PTR_ONE    = (AW+1)'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SEND  = 2'd1,
    STALL = 2'd2
  } tx_state_t;

  tx_state_t   state_q, state_d;
  logic [0:30] mem [FIFO_DEPTH];
  logic [AW:0] wr_ptr, rd_ptr, wr_ptr_d, rd_ptr_d;
  logic        ready_en;
  logic        fifo_empty, fifo_full;
  logic        push, pop, credit_ret;
  logic [3:0]  credit_d;
  logic        ovf_d;
  logic [0:30] head;
  logic        parity_bit;
  logic        unused_chan_bits;

  // Only the credit pulse is meaningful on the returning channel.
  assign credit_ret       = chanx_right_in[0];
  assign unused_chan_bits = ^chanx_right_in[1:32];

  // The extra pointer bit tells a full FIFO (MSBs differ) from an empty one.
  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                      (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  // ready_en keeps in_ready low until the first edge after reset release.
  assign in_ready = ready_en & ~fifo_full;
  assign push     = in_valid & in_ready;
  assign pop      = ~fifo_empty & (credit_count != 4'd0);
  assign head     = mem[rd_ptr[AW-1:0]];
  assign tx_state = state_q;

`ifdef CHANX_TX_PARITY_EN
  // Even parity: the parity bit makes the total count of ones even.
  assign parity_bit = ^head;
`else
  assign parity_bit = 1'b0;
`endif

  // Next-state logic. The FSM state is derived from the FIFO occupancy and
  // credit count that will hold after this edge, so tx_state always matches
  // what the datapath is about to do.
  always_comb begin
    wr_ptr_d = wr_ptr;
    rd_ptr_d = rd_ptr;
    credit_d = credit_count;
    ovf_d    = err_credit_ovf;
    state_d  = IDLE;

    if (push) wr_ptr_d = wr_ptr + PTR_ONE;
    if (pop)  rd_ptr_d = rd_ptr + PTR_ONE;

    // A send and a credit return in the same cycle cancel out. A return at
    // the maximum count is a protocol error and the count is held.
    case ({pop, credit_ret})
      2'b10: credit_d = credit_count - 4'd1;
      2'b01: begin
        if (credit_count == CREDIT_MAX) ovf_d = 1'b1;
        else                            credit_d = credit_count + 4'd1;
      end
      default: ;
    endcase

    if (wr_ptr_d == rd_ptr_d)  state_d = IDLE;
    else if (credit_d != 4'd0) state_d = SEND;
    else                       state_d = STALL;
  end

  // State, pointers, credits and the registered output channel. Reset clears
  // the channel immediately, so a flit in flight is dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= IDLE;
      wr_ptr          <= '0;
      rd_ptr          <= '0;
      ready_en        <= 1'b0;
      credit_count    <= CREDIT_MAX;
      err_credit_ovf  <= 1'b0;
      chanx_right_out <= '0;
    end else begin
      state_q         <= state_d;
      wr_ptr          <= wr_ptr_d;
      rd_ptr          <= rd_ptr_d;
      ready_en        <= 1'b1;
      credit_count    <= credit_d;
      err_credit_ovf  <= ovf_d;
      chanx_right_out <= pop ? {head, parity_bit, 1'b1} : '0;
    end
  end

  // FIFO storage needs no reset; the pointers define which entries are live.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= in_data;
  end

endmodule

// File: tb/tb_chanx_flit_tx.sv
// tb_chanx_flit_tx: self-checking bench for chanx_flit_tx.
//
// A queue-based reference model tracks FIFO contents, credits and the error
// flag from the transmitter's rules; every cycle the DUT outputs are compared
// against it. Directed scenarios cover single flit, credit exhaustion, full
// FIFO, simultaneous send/return, overflow, parity and mid-operation reset,
// followed by a randomized run. Honours CHANX_TX_PARITY_EN like the design.

module tb_chanx_flit_tx;

  localparam int DEPTH = 4;
  localparam int INIT  = 4;

  logic        clk;
  logic        rst_n;
  logic [0:30] in_data;
  logic        in_valid;
  logic        in_ready;
  logic [0:32] chanx_right_in;
  logic [0:32] chanx_right_out;
  logic [3:0]  credit_count;
  logic [1:0]  tx_state;
  logic        err_credit_ovf;

  int vec_count  = 0;
  int miss_count = 0;

  // Reference model state
  logic [0:30] mq[$];
  int          mc;
  bit          merr;
  bit          mready;
  logic [0:32] exp_out;
  int          exp_state;

  logic [0:30] flits [6];
  logic        exp_par;

  chanx_flit_tx #(
    .FIFO_DEPTH  (DEPTH),
    .INIT_CREDITS(INIT)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .in_data        (in_data),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .chanx_right_in (chanx_right_in),
    .chanx_right_out(chanx_right_out),
    .credit_count   (credit_count),
    .tx_state       (tx_state),
    .err_credit_ovf (err_credit_ovf)
  );

  // Free-running clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard time limit so the run can never hang
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic par(input logic [0:30] d);
`ifdef CHANX_TX_PARITY_EN
    return ^d;
`else
    return 1'b0;
`endif
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] got,
                             input logic [63:0] exp);
    vec_count++;
    if (got !== exp) begin
      miss_count++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    mc     = INIT;
    merr   = 1'b0;
    mready = 1'b0;
  endtask

  // One clock edge of the reference behaviour, using pre-edge model state.
  task automatic model_step(input logic v, input logic [0:30] d, input logic r);
    bit send;
    bit acc;
    send = (mq.size() > 0) && (mc > 0);
    acc  = v && mready && (mq.size() < DEPTH);
    if (send) begin
      exp_out = {mq[0], par(mq[0]), 1'b1};
      void'(mq.pop_front());
    end else begin
      exp_out = '0;
    end
    if (acc) mq.push_back(d);
    if (r && !send) begin
      if (mc == INIT) merr = 1'b1;
      else            mc++;
    end else if (send && !r) begin
      mc--;
    end
    mready    = 1'b1;
    exp_state = (mq.size() == 0) ? 0 : ((mc > 0) ? 1 : 2);
  endtask

  task automatic check_model();
    checkOutput("out",    64'(chanx_right_out), 64'(exp_out));
    checkOutput("credit", 64'(credit_count),    64'(mc));
    checkOutput("state",  64'(tx_state),        64'(exp_state));
    checkOutput("err",    64'(err_credit_ovf),  64'(merr));
    checkOutput("ready",  64'(in_ready),
                64'(mready && (mq.size() < DEPTH)));
  endtask

  task automatic applyStimulus(input logic v, input logic [0:30] d, input logic r);
    @(negedge clk);
    in_valid       = v;
    in_data        = d;
    chanx_right_in = {r, 32'($urandom())};
    model_step(v, d, r);
    @(posedge clk);
    #1;
    check_model();
  endtask

  task automatic assertReset();
    rst_n          = 1'b0;
    in_valid       = 1'b0;
    chanx_right_in = '0;
    model_reset();
    #1;
    checkOutput("rst_out",    64'(chanx_right_out), 64'd0);
    checkOutput("rst_ready",  64'(in_ready),        64'd0);
    checkOutput("rst_state",  64'(tx_state),        64'd0);
    checkOutput("rst_credit", 64'(credit_count),    64'(INIT));
    checkOutput("rst_err",    64'(err_credit_ovf),  64'd0);
  endtask

  task automatic releaseReset();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic doReset();
    @(negedge clk);
    assertReset();
    releaseReset();
  endtask

  // Return credits until the model FIFO is empty and credits are full again.
  task automatic drain();
    int n;
    n = 0;
    while ((mq.size() != 0 || mc != INIT) && n < 40) begin
      applyStimulus(1'b0, '0, mc < INIT);
      n++;
    end
    if (mq.size() != 0 || mc != INIT)
      checkOutput("drain_timeout", 64'd0, 64'd1);
  endtask

  initial begin
    int ret_pct;
    rst_n          = 1'b1;
    in_valid       = 1'b0;
    in_data        = '0;
    chanx_right_in = '0;
    model_reset();

    doReset();
    // First edge after release raises in_ready
    applyStimulus(1'b0, '0, 1'b0);

    // Single flit: one-edge latency, one-cycle valid, credit 4 -> 3
    applyStimulus(1'b1, 31'h1234, 1'b0);
    applyStimulus(1'b0, '0, 1'b0);
    checkOutput("single_valid",  64'(chanx_right_out[32]),   64'd1);
    checkOutput("single_data",   64'(chanx_right_out[0:30]), 64'h1234);
    checkOutput("single_credit", 64'(credit_count),          64'd3);
    applyStimulus(1'b0, '0, 1'b0);
    checkOutput("single_drop",   64'(chanx_right_out[32]),   64'd0);
    drain();

    // Credit exhaustion: 6 back-to-back pushes, 4 sent, then stall
    for (int i = 0; i < 6; i++) begin
      flits[i] = 31'($urandom());
      applyStimulus(1'b1, flits[i], 1'b0);
    end
    checkOutput("exh_state",  64'(tx_state),     64'd2);
    checkOutput("exh_credit", 64'(credit_count), 64'd0);
    applyStimulus(1'b0, '0, 1'b1);
    applyStimulus(1'b0, '0, 1'b0);
    checkOutput("exh_fifth_valid", 64'(chanx_right_out[32]),   64'd1);
    checkOutput("exh_fifth_data",  64'(chanx_right_out[0:30]), 64'(flits[4]));
    drain();

    // Full FIFO with no credits
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 31'($urandom()), 1'b0);
    applyStimulus(1'b0, '0, 1'b0);
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 31'($urandom()), 1'b0);
    checkOutput("full_ready", 64'(in_ready), 64'd0);
    applyStimulus(1'b1, 31'h7ABCDEF, 1'b0);
    checkOutput("full_reject_ready", 64'(in_ready), 64'd0);
    applyStimulus(1'b0, '0, 1'b1);
    applyStimulus(1'b0, '0, 1'b0);
    checkOutput("full_ready_again", 64'(in_ready), 64'd1);
    drain();

    // Send and credit return in the same cycle at credit_count = 2
    applyStimulus(1'b1, 31'h11, 1'b0);
    applyStimulus(1'b1, 31'h22, 1'b0);
    applyStimulus(1'b1, 31'h33, 1'b0);
    checkOutput("simul_pre_credit", 64'(credit_count), 64'd2);
    applyStimulus(1'b0, '0, 1'b1);
    checkOutput("simul_credit", 64'(credit_count), 64'd2);
    checkOutput("simul_sent",   64'(chanx_right_out[0:30]), 64'h33);
    drain();

    // Overflow while idle at full credits; flag sticks until reset
    applyStimulus(1'b0, '0, 1'b1);
    checkOutput("ovf_flag",   64'(err_credit_ovf), 64'd1);
    checkOutput("ovf_credit", 64'(credit_count),   64'd4);
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 31'($urandom()), 1'b0);
    checkOutput("ovf_sticky", 64'(err_credit_ovf), 64'd1);
    drain();
    doReset();
    applyStimulus(1'b0, '0, 1'b0);

    // Parity on payload 7, then reset while the flit is on the channel
    applyStimulus(1'b1, 31'h0000_0007, 1'b0);
    applyStimulus(1'b0, '0, 1'b0);
`ifdef CHANX_TX_PARITY_EN
    exp_par = 1'b1;
`else
    exp_par = 1'b0;
`endif
    checkOutput("parity_bit",   64'(chanx_right_out[31]), 64'(exp_par));
    checkOutput("parity_valid", 64'(chanx_right_out[32]), 64'd1);
    #2;
    assertReset();
    releaseReset();
    applyStimulus(1'b0, '0, 1'b0);

    // Randomized traffic with varying credit-return rates
    for (int i = 0; i < 300; i++) begin
      case ((i / 50) % 3)
        0:       ret_pct = 10;
        1:       ret_pct = 40;
        default: ret_pct = 80;
      endcase
      applyStimulus($urandom_range(99) < 70, 31'($urandom()),
                    $urandom_range(99) < ret_pct);
    end
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vec_count, miss_count);
    $finish;
  end

endmodule
